// File: rtl/l2_burst_responder.sv
// l2_burst_responder: L2 array model serving 8-beat block fills and write-backs.
// Define L2_RESP_LATENCY_EN to add the WAIT state and LATENCY access counter.

module l2_burst_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        write_l2,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        l2_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [1:0]  state
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = AW - 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT     = 2'b01,
        S_RD_BURST = 2'b10,
        S_WR_BURST = 2'b11
    } state_t;

    state_t        r_state;
    logic [2:0]    r_beat;
    logic [BW-1:0] r_blk;
    logic          r_ack;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [MEM_WORDS];

    logic [BW-1:0] w_addr_blk;
    logic          w_we;
    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_ridx;
    logic          w_unused;

    assign w_addr_blk = addr[AW+1:5];

`ifdef L2_RESP_LATENCY_EN
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    logic [3:0] r_lat;
    assign w_unused = ^{addr[31:AW+2], addr[4:0]};
`else
    assign w_unused = ^{addr[31:AW+2], addr[4:0], 4'(LATENCY)};
`endif

    // Beat 0 of a write-back lands in the IDLE cycle, straight from addr.
    assign w_we = !reset && write_l2 &&
                  (r_state == S_IDLE || r_state == S_WR_BURST);
    assign w_widx = (r_state == S_IDLE) ? {w_addr_blk, 3'd0}
                                        : {r_blk, r_beat};
    assign w_ridx = {r_blk, r_beat};

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= wdata;
        end
    end

    // RD_BURST reads one beat ahead; r_ack/r_rdata trail it by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beat  <= 3'd0;
            r_blk   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
`ifdef L2_RESP_LATENCY_EN
            r_lat   <= 4'd0;
`endif
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (write_l2) begin
                        r_blk   <= w_addr_blk;
                        r_beat  <= 3'd1;
                        r_state <= S_WR_BURST;
                    end else if (rd_req) begin
                        r_blk  <= w_addr_blk;
                        r_beat <= 3'd0;
`ifdef L2_RESP_LATENCY_EN
                        if (LAT_M1 == 4'd0) begin
                            r_state <= S_RD_BURST;
                        end else begin
                            r_lat   <= LAT_M1;
                            r_state <= S_WAIT;
                        end
`else
                        r_state <= S_RD_BURST;
`endif
                    end
                end
                S_WAIT: begin
`ifdef L2_RESP_LATENCY_EN
                    r_lat <= r_lat - 4'd1;
                    if (r_lat == 4'd1) begin
                        r_state <= S_RD_BURST;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_RD_BURST: begin
                    r_ack   <= 1'b1;
                    r_rdata <= r_mem[w_ridx];
                    r_beat  <= r_beat + 3'd1;
                    if (r_beat == 3'd7) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_BURST: begin
                    if (write_l2) begin
                        r_beat <= r_beat + 3'd1;
                        if (r_beat == 3'd7) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_beat  <= 3'd0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign l2_ack = r_ack;
    assign rdata  = r_rdata;
    assign busy   = (r_state != S_IDLE);
    assign state  = r_state;

endmodule

// File: tb/tb_l2_burst_responder.sv
// Scoreboard bench for l2_burst_responder: directed writes/reads,
// expected read beats queued at issue and checked by a negedge monitor.

module tb_l2_burst_responder;

`ifdef L2_RESP_LATENCY_EN
    localparam int L = 4;
`else
    localparam int L = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic        write_l2 = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        l2_ack;
    logic [31:0] rdata;
    logic        busy;
    logic [1:0]  state;

    l2_burst_responder #(.MEM_WORDS(1024), .LATENCY(4)) dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .write_l2(write_l2),
        .addr(addr), .wdata(wdata), .l2_ack(l2_ack), .rdata(rdata),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [31:0] m [1024];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a, input int k);
        logic [2:0] b;
        b = 3'(k);
        return int'({a[11:5], b});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_read(input logic [31:0] a, input int t, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.t = t + L + k;
            e.d = m[idx(a, k)];
            q.push_back(e);
        end
    endtask

    task automatic read_start(input logic [31:0] a, input int n,
                              output int t);
        addr = a;
        rd_req = 1'b1;
        t = cyc + 1;
        push_read(a, t, n);
        tick();
        rd_req = 1'b0;
        addr = 32'h0000_03E0;
        check("rd_busy", {31'd0, busy}, 32'd1);
        check("rd_state", {30'd0, state}, (L > 1) ? 32'd1 : 32'd2);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] base,
                            input int n);
        addr = a;
        write_l2 = 1'b1;
        for (int k = 0; k < n; k++) begin
            wdata = base + 32'(k);
            m[idx(a, k)] = base + 32'(k);
            tick();
        end
        write_l2 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (l2_ack) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected: got beat at cycle %0d want none",
                         cyc);
            end else begin
                me = q.pop_front();
                check("beat_time", 32'(cyc), 32'(me.t));
                check("beat_data", rdata, me.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) tick();
        check("rst_ack", {31'd0, l2_ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        reset = 1'b0;
        tick();

        // full write-back then read-back of block at 0x40
        do_write(32'h0000_0040, 32'h0000_00A0, 8);
        check("wr_busy", {31'd0, busy}, 32'd0);
        check("wr_state", {30'd0, state}, 32'd0);
        read_start(32'h0000_0040, 8, t);
        wait_until(t + L + 2);
        addr = 32'h0000_0080;
        wait_until(t + L + 8);
        check("rd_done", {31'd0, busy}, 32'd0);

        // aborted write keeps earlier beats, leaves the rest
        do_write(32'h0000_0080, 32'h0000_00B0, 8);
        tick();
        do_write(32'h0000_0080, 32'h0000_00C0, 3);
        check("ab_busy", {31'd0, busy}, 32'd1);
        tick();
        check("ab_state", {30'd0, state}, 32'd0);
        check("ab_model3", m[idx(32'h80, 3)], 32'h0000_00B3);
        read_start(32'h0000_0080, 8, t);
        wait_until(t + L + 8);

        // write and read together: write first, read right after
        addr = 32'h0000_0100;
        rd_req = 1'b1;
        write_l2 = 1'b1;
        t = cyc + 1;
        for (int k = 0; k < 8; k++) m[idx(32'h100, k)] = 32'h0000_00D0 + 32'(k);
        push_read(32'h0000_0100, t + 8, 8);
        for (int k = 0; k < 8; k++) begin
            wdata = 32'h0000_00D0 + 32'(k);
            tick();
        end
        write_l2 = 1'b0;
        check("both_idle", {30'd0, state}, 32'd0);
        tick();
        check("both_rd", {31'd0, busy}, 32'd1);
        rd_req = 1'b0;
        wait_until(t + 8 + L + 8);

        // reset during the 4th read beat truncates the burst
        read_start(32'h0000_0040, 4, t);
        wait_until(t + L + 3);
        reset = 1'b1;
        tick();
        check("trunc_ack", {31'd0, l2_ack}, 32'd0);
        check("trunc_state", {30'd0, state}, 32'd0);
        check("trunc_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();
        read_start(32'h0000_0040, 8, t);
        wait_until(t + L + 10);

        check("beats_left", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
